// File: rtl/spm_mem_responder.sv
// Memory-side responder for the SpMV fetch req/resp interface: an in-order request queue that
// answers each accepted line read after a fixed latency from a preloadable 64 B line store.
module spm_mem_responder #(
    parameter int  NUM_LINES = 256,
    parameter int  LAT       = 4,
    parameter int  DEPTH     = 8,
    localparam int IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int OCC_W     = $clog2(DEPTH + 1),
    localparam int DATA_W    = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req_val,
    output logic              mem_req_rdy,
    input  logic [5:0]        mem_req_transid,
    input  logic [39:0]       mem_req_addr,
    output logic              mem_resp_val,
    output logic [5:0]        mem_resp_transid,
    output logic [DATA_W-1:0] mem_resp_data,
    input  logic              resp_hold,
    input  logic              ld_val,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic              addr_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W = $clog2(LAT + 1);

    localparam logic [AGE_W-1:0] AGE_ONE     = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_MAX     = AGE_W'(LAT);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_ONE     = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(DEPTH);
    localparam logic [33:0]      LINES_LIMIT = 34'(NUM_LINES);

    typedef struct packed {
        logic [5:0]       transid;
        logic [IDX_W-1:0] line;
        logic             oob;
    } entry_t;

    logic [DATA_W-1:0] store   [NUM_LINES];
    entry_t            entry_q [DEPTH];
    logic [AGE_W-1:0]  age_q   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    entry_t           req_entry;
    entry_t           head_entry;
    logic             push;
    logic             pop;
    logic             unused_addr_offset;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Only registered state feeds rdy, so a pop in the same cycle never opens a slot early.
    assign mem_req_rdy        = rst_n && (occupancy < OCC_FULL);
    assign unused_addr_offset = ^mem_req_addr[5:0];

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output on every pass,
        // so the block reads top to bottom and can never infer a latch.
        req_entry.transid = mem_req_transid;
        req_entry.line    = mem_req_addr[6 +: IDX_W];
        req_entry.oob     = (mem_req_addr[39:6] >= LINES_LIMIT);
        head_entry        = entry_q[head];
        push              = mem_req_val && mem_req_rdy;
        pop               = (occupancy != '0) && (age_q[head] == AGE_MAX) && !resp_hold;
    end

    // NOTE: the line store and the queue payload are plain RAM with no reset; validity comes
    // from the reset head/tail/occupancy, and the store must survive reset by design.
    always_ff @(posedge clk) begin
        if (ld_val) begin
            store[ld_idx] <= ld_data;
        end
    end

    // An entry is written with age 1 because the handshake cycle itself counts as age 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] != AGE_MAX) begin
                age_q[i] <= age_q[i] + AGE_ONE;
            end
        end
        if (push) begin
            entry_q[tail] <= req_entry;
            age_q[tail]   <= AGE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head             <= '0;
            tail             <= '0;
            occupancy        <= '0;
            addr_err         <= 1'b0;
            mem_resp_val     <= 1'b0;
            mem_resp_transid <= '0;
            mem_resp_data    <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
            if (push && req_entry.oob) begin
                addr_err <= 1'b1;
            end
            // The store read sees the value before any same-edge preload write.
            mem_resp_val <= pop;
            if (pop) begin
                mem_resp_transid <= head_entry.transid;
                mem_resp_data    <= head_entry.oob ? '0 : store[head_entry.line];
            end
        end
    end

endmodule
